instr_encoder: RTL



---
 rtl/lab2_isa_pkg.sv | 11 +
 rtl/instr_fifo.sv | 42 ++++
 rtl/instr_encoder.sv | 116 +++++++++++
 3 files changed

// File: rtl/lab2_isa_pkg.sv
// lab2_isa_pkg: shared ISA opcodes, encoder error codes and encoder FSM states
package lab2_isa_pkg;
  typedef enum logic [3:0] {
    ADD   = 4'h0, ADDI  = 4'h1, SUB  = 4'h2, LD   = 4'h3,
    ST    = 4'h4, STL   = 4'h5, BEQ0 = 4'h6, J    = 4'h7,
    SHL   = 4'h8, PUSHV = 4'h9, POPV = 4'hA, ADDRC = 4'hB,
    CMP4  = 4'hC, CLR   = 4'hD, HALT = 4'hE, TBD  = 4'hF
  } opcode_e;
  typedef enum logic [1:0] {ERR_NONE, ERR_ILLEGAL, ERR_RANGE, ERR_OVF} err_code_e;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_e;
endpackage

// File: rtl/instr_fifo.sv
// instr_fifo: synchronous power-of-two FIFO with flush for encoded instruction words
module instr_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] count;
  logic do_push, do_pop;
  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rp];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else if (flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      wp    <= wp + AW'(do_push);
      rp    <= rp + AW'(do_pop);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push && !flush) mem[wp] <= din;
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: packs symbolic instructions into 8-bit ISA words and writes them to imem (INSTR_ENC_CHECK_EN adds opcode/range checks)
module instr_encoder
  import lab2_isa_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int IMEM_AW    = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [3:0]         op_i,
  input  logic [2:0]         ra_i,
  input  logic [2:0]         rb_i,
  input  logic [3:0]         imm_i,
  output logic               imem_we_o,
  input  logic               imem_ready_i,
  output logic [IMEM_AW-1:0] imem_addr_o,
  output logic [7:0]         imem_wdata_o,
  output logic               done_o,
  output logic               err_o,
  output logic [1:0]         err_code_o
);
  state_e state, state_nxt;
  err_code_e err_code, err_nxt, rej_code;
  opcode_e op;
  logic [IMEM_AW-1:0] addr;
  logic [7:0] word, head;
  logic full, empty, accept, rej, wr_done, head_halt, ovf;

  function automatic logic [7:0] pack(opcode_e o, logic [2:0] ra, logic [2:0] rb, logic [3:0] imm);
    logic [3:0] f;
    case (o)
      ADD, SUB, LD, ST, CMP4: f = {ra[1:0], rb[1:0]};
      ADDI, SHL:              f = {ra[1:0], imm[1:0]};
      ADDRC:                  f = {ra[1:0], 2'b00};
      PUSHV, POPV, CLR, TBD:  f = {1'b0, ra};
      BEQ0, J:                f = imm;
      default:                f = 4'h0;
    endcase
    return {o, f};
  endfunction

`ifdef INSTR_ENC_CHECK_EN
  function automatic err_code_e check(opcode_e o, logic [2:0] ra, logic [2:0] rb, logic [3:0] imm);
    err_code_e e;
    e = ERR_NONE;
    case (o)
      STL:                    e = ERR_ILLEGAL;
      ADD, SUB, LD, ST, CMP4: e = (ra[2] || rb[2] || imm != 4'd0) ? ERR_RANGE : ERR_NONE;
      ADDI, SHL:              e = (ra[2] || imm > 4'd3) ? ERR_RANGE : ERR_NONE;
      ADDRC:                  e = (ra[2] || imm != 4'd0) ? ERR_RANGE : ERR_NONE;
      PUSHV, POPV, CLR, TBD:  e = (imm != 4'd0) ? ERR_RANGE : ERR_NONE;
      default:                e = ERR_NONE;
    endcase
    return e;
  endfunction
  assign rej_code = check(op, ra_i, rb_i, imm_i);
`else
  assign rej_code = ERR_NONE;
`endif

  assign op           = opcode_e'(op_i);
  assign word         = pack(op, ra_i, rb_i, imm_i);
  assign rej          = rej_code != ERR_NONE;
  assign in_ready_o   = state == S_LOAD && !full;
  assign accept       = in_valid_i && in_ready_o;
  assign imem_we_o    = !empty;
  assign wr_done      = imem_we_o && imem_ready_i;
  assign head_halt    = head[7:4] == HALT;
  assign ovf          = wr_done && !head_halt && addr == '1;
  assign imem_addr_o  = addr;
  assign imem_wdata_o = empty ? 8'h00 : head;
  assign done_o       = state == S_DONE;
  assign err_o        = err_code != ERR_NONE;
  assign err_code_o   = err_code;

  instr_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .flush  (start_i || ovf),
    .push   (accept && !rej),
    .pop    (wr_done),
    .din    (word),
    .dout   (head),
    .full   (full),
    .empty  (empty)
  );

  always_comb begin
    state_nxt = start_i ? S_LOAD
              : ovf ? S_DONE
              : (state == S_LOAD && accept && op == HALT) ? S_DRAIN
              : (state == S_DRAIN && wr_done && head_halt) ? S_DONE
              : state;
    err_nxt   = start_i ? ERR_NONE
              : err_code != ERR_NONE ? err_code
              : ovf ? ERR_OVF
              : (accept && rej) ? rej_code
              : ERR_NONE;
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= S_IDLE;
    else state <= state_nxt;

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      addr     <= '0;
      err_code <= ERR_NONE;
    end else begin
      addr     <= start_i ? '0 : wr_done ? addr + 1'b1 : addr;
      err_code <= err_nxt;
    end
endmodule
